pipelined_cla_adder: RTL and testbench

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

---
 rtl/pipelined_cla_adder_pkg.sv | 20 ++
 rtl/pipelined_cla_adder_cla_slice.sv | 41 ++++
 rtl/pipelined_cla_adder.sv | 106 ++++++++++
 tb/tb_pipelined_cla_adder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_cla_adder_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder.
package pipelined_cla_adder_pkg;

  localparam int unsigned MAX_N = 64;

  // Stage record sized for the widest supported operand; unused upper bits stay zero.
  typedef struct packed {
    logic             valid;
    logic [MAX_N-1:0] a;
    logic [MAX_N-1:0] b;
    logic [MAX_N-1:0] s;
    logic             carry;
    logic             sub;
  } stage_t;

  function automatic int unsigned num_stages(input int unsigned n, input int unsigned blk);
    return (blk == 0) ? 0 : n / blk;
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_cla_slice.sv
// BLK-bit combinational carry-lookahead block: every carry is formed directly from P/G and ci.
module cla_slice #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb_in
);

  logic [W-1:0] p;
  logic [W-1:0] g;
  logic [W:0]   c;

  assign p = a ^ b;
  assign g = a & b;

  always_comb begin
    logic term;
    term = 1'b0;
    c    = '0;
    c[0] = ci;
    for (int unsigned i = 1; i <= W; i++) begin
      term = ci;
      for (int unsigned j = 0; j < i; j++) term = term & p[j];
      c[i] = term;
      for (int unsigned j = 0; j < i; j++) begin
        term = g[j];
        for (int unsigned m = j + 1; m < i; m++) term = term & p[m];
        c[i] = c[i] | term;
      end
    end
  end

  assign s        = p ^ c[W-1:0];
  assign co       = c[W];
  assign c_msb_in = c[W-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined adder/subtractor: one lookahead block resolved per stage, operands skewed alongside.
module pipelined_cla_adder
  import pipelined_cla_adder_pkg::*;
#(
  parameter int unsigned N   = 16,
  parameter int unsigned BLK = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic         sub,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] S,
  output logic         Cout,
  output logic         V,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int unsigned L = num_stages(N, BLK);

  if (BLK < 1) begin : g_err_blk
    $error("pipelined_cla_adder: BLK must be at least 1");
  end else if (N % BLK != 0) begin : g_err_div
    $error("pipelined_cla_adder: N must be a multiple of BLK");
  end
  if (N > MAX_N) begin : g_err_width
    $error("pipelined_cla_adder: N exceeds MAX_N");
  end

  stage_t         st  [L];
  stage_t         nxt [L];
  stage_t         in_rec;
  logic [L-1:0]   co_v;
  logic [L-1:0]   cmsb_v;
  logic           adv;
  logic           ovf;
  logic           ovf_nxt;

  // B is inverted and the carry forced high up front, so later stages never look at sub.
  always_comb begin
    in_rec          = '0;
    in_rec.valid    = in_valid;
    in_rec.a[N-1:0] = A;
    in_rec.b[N-1:0] = sub ? ~B : B;
    in_rec.carry    = sub | Cin;
    in_rec.sub      = sub;
  end

  for (genvar k = 0; k < L; k++) begin : g_stage
    stage_t         src;
    stage_t         upd;
    logic [BLK-1:0] s_blk;

    if (k == 0) begin : g_first
      assign src = in_rec;
    end else begin : g_next
      assign src = st[k-1];
    end

    cla_slice #(.W(BLK)) u_slice (
      .a        (src.a[k*BLK +: BLK]),
      .b        (src.b[k*BLK +: BLK]),
      .ci       (src.carry),
      .s        (s_blk),
      .co       (co_v[k]),
      .c_msb_in (cmsb_v[k])
    );

    always_comb begin
      upd                   = src;
      upd.s[k*BLK +: BLK]   = s_blk;
      upd.carry             = co_v[k];
    end

    assign nxt[k] = upd;
  end

  assign ovf_nxt = co_v[L-1] ^ cmsb_v[L-1];

  // Only valid bits are cleared in the inner stages; the last stage doubles as the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < L; k++) st[k].valid <= 1'b0;
      st[L-1] <= '0;
      ovf     <= 1'b0;
    end else if (adv) begin
      for (int unsigned k = 0; k < L; k++) st[k] <= nxt[k];
      ovf <= ovf_nxt;
    end
  end

  assign adv       = !st[L-1].valid | out_ready;
  assign in_ready  = adv;
  assign out_valid = st[L-1].valid;
  assign S         = st[L-1].s[N-1:0];
  assign Cout      = st[L-1].carry;
  assign V         = ovf;

  logic unused_tail;
  assign unused_tail = ^{st[L-1].a, st[L-1].b, st[L-1].sub, st[L-1].s, co_v, cmsb_v};

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench: directed vectors on BLK=4 plus randomized scoreboard runs for BLK 1/4/16.
module tb_pipelined_cla_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] a_s [3];
  logic [15:0] b_s [3];
  logic [15:0] s_s [3];
  logic        cin_s [3];
  logic        sub_s [3];
  logic        iv_s  [3];
  logic        ir_s  [3];
  logic        ov_s  [3];
  logic        or_s  [3];
  logic        co_s  [3];
  logic        v_s   [3];

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [17:0] exp;
    int          stl;
    int          cyc;
    bit          seen;
  } item_t;

  pipelined_cla_adder #(.N(16), .BLK(4)) u_b4 (
    .clk(clk), .rst(rst), .A(a_s[0]), .B(b_s[0]), .Cin(cin_s[0]), .sub(sub_s[0]),
    .in_valid(iv_s[0]), .in_ready(ir_s[0]), .S(s_s[0]), .Cout(co_s[0]), .V(v_s[0]),
    .out_valid(ov_s[0]), .out_ready(or_s[0])
  );

  pipelined_cla_adder #(.N(16), .BLK(1)) u_b1 (
    .clk(clk), .rst(rst), .A(a_s[1]), .B(b_s[1]), .Cin(cin_s[1]), .sub(sub_s[1]),
    .in_valid(iv_s[1]), .in_ready(ir_s[1]), .S(s_s[1]), .Cout(co_s[1]), .V(v_s[1]),
    .out_valid(ov_s[1]), .out_ready(or_s[1])
  );

  pipelined_cla_adder #(.N(16), .BLK(16)) u_b16 (
    .clk(clk), .rst(rst), .A(a_s[2]), .B(b_s[2]), .Cin(cin_s[2]), .sub(sub_s[2]),
    .in_valid(iv_s[2]), .in_ready(ir_s[2]), .S(s_s[2]), .Cout(co_s[2]), .V(v_s[2]),
    .out_valid(ov_s[2]), .out_ready(or_s[2])
  );

  // Reference: integer arithmetic on the operand values, returns {cout, v, s}.
  function automatic logic [17:0] ref_calc(input logic [15:0] a, input logic [15:0] b,
                                           input logic ci, input logic sb);
    int          sa;
    int          sbv;
    int          r;
    logic [15:0] s;
    logic        co;
    logic        v;
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    if (sb) begin
      r  = sa - sbv;
      s  = a - b;
      co = (a >= b);
    end else begin
      r  = sa + sbv + int'(ci);
      s  = a + b + 16'(ci);
      co = (32'(a) + 32'(b) + 32'(ci)) > 32'h0000FFFF;
    end
    v = (r > 32767) || (r < -32768);
    return {co, v, s};
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0:       return 16'hFFFF;
      1:       return 16'h8000;
      2:       return 16'h7FFF;
      3:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  // Drives one cycle on instance i; returns the outputs seen just before the clock edge.
  task automatic step(input int i, input logic iv, input logic [15:0] a, input logic [15:0] b,
                      input logic ci, input logic sb, input logic ordy,
                      output logic rdy, output logic ov, output logic [15:0] s,
                      output logic co, output logic v);
    iv_s[i]  = iv;
    a_s[i]   = a;
    b_s[i]   = b;
    cin_s[i] = ci;
    sub_s[i] = sb;
    or_s[i]  = ordy;
    #1;
    rdy = ir_s[i];
    ov  = ov_s[i];
    s   = s_s[i];
    co  = co_s[i];
    v   = v_s[i];
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic rdy, ov, co, v;
    logic [15:0] s;
    rst = 1'b1;
    step(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, rdy, ov, s, co, v);
    step(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, rdy, ov, s, co, v);
    rst = 1'b0;
    step(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, rdy, ov, s, co, v);
    tests++; if (ov !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", ov); end
    tests++; if (s !== 16'h0) begin fails++; $display("FAIL reset_S: got %h want 0000", s); end
    tests++; if (co !== 1'b0) begin fails++; $display("FAIL reset_Cout: got %b want 0", co); end
    tests++; if (v !== 1'b0) begin fails++; $display("FAIL reset_V: got %b want 0", v); end
    tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", rdy); end
  endtask

  task automatic test_directed();
    logic [15:0] ta [4] = '{16'h1234, 16'hFFFF, 16'h8000, 16'h0003};
    logic [15:0] tb [4] = '{16'h0FED, 16'h0001, 16'h0001, 16'h0005};
    logic        tc [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic        tsb[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] es [4] = '{16'h2222, 16'h0000, 16'h7FFF, 16'hFFFE};
    logic        eco[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic        ev [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic rdy, ov, co, v;
    logic [15:0] s;
    int lat;
    for (int t = 0; t < 4; t++) begin
      step(0, 1'b1, ta[t], tb[t], tc[t], tsb[t], 1'b1, rdy, ov, s, co, v);
      tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL dir%0d_accept: in_ready %b want 1", t, rdy); end
      lat = 0;
      for (int c = 1; c <= 20; c++) begin
        step(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, rdy, ov, s, co, v);
        if (ov) begin lat = c; break; end
      end
      tests++; if (lat != 4) begin fails++; $display("FAIL dir%0d_latency: got %0d want 4", t, lat); end
      tests++; if (s !== es[t]) begin fails++; $display("FAIL dir%0d_S: got %h want %h", t, s, es[t]); end
      tests++; if (co !== eco[t]) begin fails++; $display("FAIL dir%0d_Cout: got %b want %b", t, co, eco[t]); end
      tests++; if (v !== ev[t]) begin fails++; $display("FAIL dir%0d_V: got %b want %b", t, v, ev[t]); end
    end
  endtask

  task automatic test_back_to_back();
    logic rdy, ov, co, v, ordy, iv, ci, sb;
    logic [15:0] s, a, b;
    logic [17:0] q[$];
    int sent = 0, recv = 0, stall_seen = 0;
    for (int c = 1; c <= 60 && recv < 8; c++) begin
      iv   = (sent < 8);
      ordy = !(c >= 5 && c <= 7);
      a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); sb = 1'($urandom);
      step(0, iv, a, b, ci, sb, ordy, rdy, ov, s, co, v);
      if (!ordy) begin
        stall_seen++;
        tests++; if (rdy !== 1'b0) begin fails++; $display("FAIL b2b_stall_ready c%0d: got %b want 0", c, rdy); end
      end
      if (ov) begin
        tests++;
        if (q.size() == 0) begin
          fails++; $display("FAIL b2b_extra c%0d: result %h with none pending", c, {co, v, s});
        end else begin
          if ({co, v, s} !== q[0]) begin
            fails++; $display("FAIL b2b_result c%0d: got %h want %h", c, {co, v, s}, q[0]);
          end
          if (ordy) begin void'(q.pop_front()); recv++; end
        end
      end else if (!ordy) begin
        tests++; fails++; $display("FAIL b2b_stall_valid c%0d: out_valid %b want 1", c, ov);
      end
      if (iv && rdy) begin q.push_back(ref_calc(a, b, ci, sb)); sent++; end
    end
    tests++; if (recv != 8) begin fails++; $display("FAIL b2b_count: got %0d want 8", recv); end
    tests++; if (stall_seen != 3) begin fails++; $display("FAIL b2b_stall_cycles: got %0d want 3", stall_seen); end
  endtask

  task automatic test_reset_flush();
    logic rdy, ov, co, v;
    logic [15:0] s;
    for (int c = 0; c < 3; c++)
      step(0, 1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1, rdy, ov, s, co, v);
    rst = 1'b1;
    step(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, rdy, ov, s, co, v);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, rdy, ov, s, co, v);
      tests++; if (ov !== 1'b0) begin fails++; $display("FAIL flush_stale c%0d: out_valid %b want 0", c, ov); end
    end
  endtask

  task automatic test_random(input int i, input int lat, input int n);
    logic rdy, ov, co, v, ordy, iv, ci, sb;
    logic [15:0] s, a, b;
    item_t q[$];
    item_t it;
    int sent = 0, stl = 0, cyc = 0;
    int budget;
    budget = n * 10 + 200;
    rst = 1'b1;
    step(i, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, rdy, ov, s, co, v);
    rst = 1'b0;
    while ((sent < n || q.size() > 0) && cyc < budget) begin
      iv   = (sent < n) && ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      a = pick(); b = pick(); ci = 1'($urandom); sb = 1'($urandom);
      step(i, iv, a, b, ci, sb, ordy, rdy, ov, s, co, v);
      tests++;
      if (rdy !== (!ov || ordy)) begin
        fails++; $display("FAIL rand%0d_ready c%0d: got %b want %b", i, cyc, rdy, (!ov || ordy));
      end
      if (ov) begin
        tests++;
        if (q.size() == 0) begin
          fails++; $display("FAIL rand%0d_extra c%0d: result %h with none pending", i, cyc, {co, v, s});
        end else begin
          if ({co, v, s} !== q[0].exp) begin
            fails++; $display("FAIL rand%0d_result c%0d: got %h want %h", i, cyc, {co, v, s}, q[0].exp);
          end
          if (!q[0].seen) begin
            q[0].seen = 1'b1;
            if (q[0].stl == stl) begin
              tests++;
              if (cyc - q[0].cyc != lat) begin
                fails++; $display("FAIL rand%0d_latency c%0d: got %0d want %0d", i, cyc, cyc - q[0].cyc, lat);
              end
            end
          end
          if (ordy) void'(q.pop_front());
        end
        if (!ordy) stl++;
      end
      if (iv && rdy) begin
        it.exp  = ref_calc(a, b, ci, sb);
        it.stl  = stl;
        it.cyc  = cyc;
        it.seen = 1'b0;
        q.push_back(it);
        sent++;
      end
      cyc++;
    end
    tests++;
    if (sent < n || q.size() > 0) begin
      fails++; $display("FAIL rand%0d_drain: sent %0d pending %0d want %0d/0", i, sent, q.size(), n);
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv_s[i] = 1'b0; or_s[i] = 1'b0; a_s[i] = '0; b_s[i] = '0; cin_s[i] = 1'b0; sub_s[i] = 1'b0;
    end
    @(negedge clk);
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_flush();
    test_random(0, 4, 3000);
    test_random(1, 16, 3000);
    test_random(2, 1, 3000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
